// File: rtl/csr_trap_unit_if.sv
// CSR access, trap/return request and status bundle between the execute stage and csr_trap_unit.
interface csr_trap_unit_if;
  logic [11:0] i_csr_addr;
  logic [1:0]  i_csr_op;
  logic [31:0] i_csr_wdata;
  logic [31:0] o_csr_rdata;
  logic        o_illegal;
  logic        i_trap;
  logic        i_trap_is_int;
  logic [4:0]  i_trap_code;
  logic [31:0] i_trap_pc;
  logic [31:0] i_trap_tval;
  logic        i_mret;
  logic        i_sret;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic [1:0]  o_priv;
  logic [31:0] o_satp;
  logic [31:0] o_mstatus;

  modport master (
    output i_csr_addr, i_csr_op, i_csr_wdata, i_trap, i_trap_is_int, i_trap_code,
           i_trap_pc, i_trap_tval, i_mret, i_sret,
    input  o_csr_rdata, o_illegal, o_redirect, o_redirect_pc, o_priv, o_satp, o_mstatus
  );

  modport slave (
    input  i_csr_addr, i_csr_op, i_csr_wdata, i_trap, i_trap_is_int, i_trap_code,
           i_trap_pc, i_trap_tval, i_mret, i_sret,
    output o_csr_rdata, o_illegal, o_redirect, o_redirect_pc, o_priv, o_satp, o_mstatus
  );
endinterface

// File: rtl/csr_trap_unit.sv
// M/S/U CSR file with read-modify-write ops, trap entry with delegation, xRET and a 64-bit time counter.
module csr_trap_unit #(
  parameter int unsigned HART_ID     = 0,
  parameter int unsigned TIME_DIV    = 1,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  csr_trap_unit_if.slave bus
);
  localparam int          PW           = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TIME_DIV - 1);
  localparam logic [31:0] SSTATUS_MASK = 32'h000C_0122;
  localparam logic [1:0]  PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11;

  logic [31:0] r_mstatus, r_medeleg, r_mideleg, r_mie, r_mtvec, r_mcounteren;
  logic [31:0] r_mscratch, r_mepc, r_mcause, r_mtval, r_mip;
  logic [31:0] r_stvec, r_sscratch, r_sepc, r_scause, r_stval, r_satp;
  logic [1:0]  r_priv;
  logic [63:0] r_time;
  logic [PW-1:0] r_presc;
  logic [31:0] r_rdata, r_redirect_pc;
  logic        r_illegal, r_redirect;

  logic [31:0] w_old, w_new, w_tvec, w_vec;
  logic        w_impl, w_wr, w_is_time, w_csr_illegal, w_deleg;

  always_comb begin
    w_old  = 32'h0;
    w_impl = 1'b1;
    case (bus.i_csr_addr)
      12'h300: w_old = r_mstatus;
      12'h302: w_old = r_medeleg;
      12'h303: w_old = r_mideleg;
      12'h304: w_old = r_mie;
      12'h305: w_old = r_mtvec;
      12'h306: w_old = r_mcounteren;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h343: w_old = r_mtval;
      12'h344: w_old = r_mip;
      12'h100: w_old = r_mstatus & SSTATUS_MASK;
      12'h104: w_old = r_mie & r_mideleg;
      12'h105: w_old = r_stvec;
      12'h140: w_old = r_sscratch;
      12'h141: w_old = r_sepc;
      12'h142: w_old = r_scause;
      12'h143: w_old = r_stval;
      12'h144: w_old = r_mip & r_mideleg;
      12'h180: w_old = r_satp;
      12'hC01: w_old = r_time[31:0];
      12'hC81: w_old = r_time[63:32];
      12'hF14: w_old = HART_ID;
      default: w_impl = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.i_csr_op)
      2'b01:   w_new = bus.i_csr_wdata;
      2'b10:   w_new = w_old | bus.i_csr_wdata;
      2'b11:   w_new = w_old & ~bus.i_csr_wdata;
      default: w_new = w_old;
    endcase
  end

  // set/clear with a zero operand is a pure read and never counts as a write
  assign w_wr          = (bus.i_csr_op == 2'b01) || (bus.i_csr_wdata != 32'h0);
  assign w_is_time     = (bus.i_csr_addr == 12'hC01) || (bus.i_csr_addr == 12'hC81);
  assign w_csr_illegal = !w_impl || (r_priv < bus.i_csr_addr[9:8])
                       || (w_wr && bus.i_csr_addr[11:10] == 2'b11)
                       || (w_is_time && r_priv != PRIV_M && !r_mcounteren[1]);

  assign w_deleg = (r_priv != PRIV_M) &&
                   (bus.i_trap_is_int ? r_mideleg[bus.i_trap_code] : r_medeleg[bus.i_trap_code]);
  assign w_tvec  = w_deleg ? r_stvec : r_mtvec;
  assign w_vec   = {w_tvec[31:2], 2'b00} +
                   ((w_tvec[1:0] == 2'b01 && bus.i_trap_is_int) ? {25'h0, bus.i_trap_code, 2'b00} : 32'h0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_time  <= 64'h0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_time  <= r_time + 64'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mstatus <= 32'h0; r_medeleg <= 32'h0; r_mideleg <= 32'h0; r_mie <= 32'h0;
      r_mtvec <= MTVEC_RESET; r_mcounteren <= 32'h0; r_mscratch <= 32'h0;
      r_mepc <= 32'h0; r_mcause <= 32'h0; r_mtval <= 32'h0; r_mip <= 32'h0;
      r_stvec <= 32'h0; r_sscratch <= 32'h0; r_sepc <= 32'h0; r_scause <= 32'h0;
      r_stval <= 32'h0; r_satp <= 32'h0;
      r_priv <= PRIV_M;
      r_rdata <= 32'h0; r_illegal <= 1'b0; r_redirect <= 1'b0; r_redirect_pc <= 32'h0;
    end else begin
      r_illegal  <= 1'b0;
      r_redirect <= 1'b0;
      if (bus.i_trap) begin
        r_redirect    <= 1'b1;
        r_redirect_pc <= w_vec;
        if (w_deleg) begin
          r_sepc       <= bus.i_trap_pc;
          r_scause     <= {bus.i_trap_is_int, 26'h0, bus.i_trap_code};
          r_stval      <= bus.i_trap_tval;
          r_mstatus[5] <= r_mstatus[1];
          r_mstatus[1] <= 1'b0;
          r_mstatus[8] <= r_priv[0];
          r_priv       <= PRIV_S;
        end else begin
          r_mepc             <= bus.i_trap_pc;
          r_mcause           <= {bus.i_trap_is_int, 26'h0, bus.i_trap_code};
          r_mtval            <= bus.i_trap_tval;
          r_mstatus[7]       <= r_mstatus[3];
          r_mstatus[3]       <= 1'b0;
          r_mstatus[12:11]   <= r_priv;
          r_priv             <= PRIV_M;
        end
      end else if (bus.i_mret) begin
        if (r_priv == PRIV_M) begin
          r_priv           <= r_mstatus[12:11];
          r_mstatus[3]     <= r_mstatus[7];
          r_mstatus[7]     <= 1'b1;
          r_mstatus[12:11] <= PRIV_U;
          r_redirect       <= 1'b1;
          r_redirect_pc    <= r_mepc;
        end else begin
          r_illegal <= 1'b1;
        end
      end else if (bus.i_sret) begin
        if (r_priv != PRIV_U) begin
          r_priv        <= r_mstatus[8] ? PRIV_S : PRIV_U;
          r_mstatus[1]  <= r_mstatus[5];
          r_mstatus[5]  <= 1'b1;
          r_mstatus[8]  <= 1'b0;
          r_redirect    <= 1'b1;
          r_redirect_pc <= r_sepc;
        end else begin
          r_illegal <= 1'b1;
        end
      end else if (bus.i_csr_op != 2'b00) begin
        if (w_csr_illegal) begin
          r_illegal <= 1'b1;
          r_rdata   <= 32'h0;
        end else begin
          r_rdata <= w_old;
          if (w_wr) begin
            case (bus.i_csr_addr)
              12'h300: r_mstatus    <= w_new;
              12'h302: r_medeleg    <= w_new;
              12'h303: r_mideleg    <= w_new;
              12'h304: r_mie        <= w_new;
              12'h305: r_mtvec      <= w_new;
              12'h306: r_mcounteren <= w_new;
              12'h340: r_mscratch   <= w_new;
              12'h341: r_mepc       <= w_new;
              12'h342: r_mcause     <= w_new;
              12'h343: r_mtval      <= w_new;
              12'h344: r_mip        <= w_new;
              12'h100: r_mstatus    <= (r_mstatus & ~SSTATUS_MASK) | (w_new & SSTATUS_MASK);
              12'h104: r_mie        <= (r_mie & ~r_mideleg) | (w_new & r_mideleg);
              12'h105: r_stvec      <= w_new;
              12'h140: r_sscratch   <= w_new;
              12'h141: r_sepc       <= w_new;
              12'h142: r_scause     <= w_new;
              12'h143: r_stval      <= w_new;
              12'h144: r_mip        <= (r_mip & ~r_mideleg) | (w_new & r_mideleg);
              12'h180: r_satp       <= w_new;
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign bus.o_csr_rdata   = r_rdata;
  assign bus.o_illegal     = r_illegal;
  assign bus.o_redirect    = r_redirect;
  assign bus.o_redirect_pc = r_redirect_pc;
  assign bus.o_priv        = r_priv;
  assign bus.o_satp        = r_satp;
  assign bus.o_mstatus     = r_mstatus;
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: expected responses are queued at drive time and checked one cycle later.
module tb_csr_trap_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_trap_unit_if bus();

  csr_trap_unit #(
    .HART_ID(3), .TIME_DIV(4), .MTVEC_RESET(32'h0000_1000)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        ill;
    logic        red;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] model_rd = 32'h0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_csr_addr = 12'h0; bus.i_csr_op = 2'b00; bus.i_csr_wdata = 32'h0;
    bus.i_trap = 1'b0; bus.i_trap_is_int = 1'b0; bus.i_trap_code = 5'h0;
    bus.i_trap_pc = 32'h0; bus.i_trap_tval = 32'h0; bus.i_mret = 1'b0; bus.i_sret = 1'b0;
  endtask

  task automatic run_step(string tag, logic [31:0] erd, logic eill, logic ered, logic [31:0] epc);
    exp_t e;
    e = '{rd: erd, ill: eill, red: ered, pc: epc};
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    idle();
    e = sb.pop_front();
    chk({tag, ".rdata"}, 64'(bus.o_csr_rdata), 64'(e.rd));
    chk({tag, ".illegal"}, 64'(bus.o_illegal), 64'(e.ill));
    chk({tag, ".redirect"}, 64'(bus.o_redirect), 64'(e.red));
    if (e.red) chk({tag, ".redirect_pc"}, 64'(bus.o_redirect_pc), 64'(e.pc));
    $display("step %-16s rdata=%h illegal=%b redirect=%b pc=%h priv=%b", tag,
             bus.o_csr_rdata, bus.o_illegal, bus.o_redirect, bus.o_redirect_pc, bus.o_priv);
  endtask

  task automatic csr(string tag, logic [11:0] a, logic [1:0] op, logic [31:0] wd,
                     logic [31:0] erd, logic eill);
    bus.i_csr_addr = a; bus.i_csr_op = op; bus.i_csr_wdata = wd;
    model_rd = eill ? 32'h0 : erd;
    run_step(tag, model_rd, eill, 1'b0, 32'h0);
  endtask

  task automatic trap(string tag, logic is_int, logic [4:0] code, logic [31:0] pc,
                      logic [31:0] tval, logic [31:0] evec);
    bus.i_trap = 1'b1; bus.i_trap_is_int = is_int; bus.i_trap_code = code;
    bus.i_trap_pc = pc; bus.i_trap_tval = tval;
    run_step(tag, model_rd, 1'b0, 1'b1, evec);
  endtask

  task automatic xret(string tag, logic is_m, logic eill, logic [31:0] epc);
    if (is_m) bus.i_mret = 1'b1; else bus.i_sret = 1'b1;
    run_step(tag, model_rd, eill, !eill, epc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    idle();
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.rdata", 64'(bus.o_csr_rdata), 64'h0);
    chk("rst.illegal", 64'(bus.o_illegal), 64'h0);
    chk("rst.redirect", 64'(bus.o_redirect), 64'h0);
    chk("rst.redirect_pc", 64'(bus.o_redirect_pc), 64'h0);
    chk("rst.priv", 64'(bus.o_priv), 64'h3);
    chk("rst.mstatus", 64'(bus.o_mstatus), 64'h0);
    chk("rst.satp", 64'(bus.o_satp), 64'h0);
    rst_n = 1'b1;

    // time prescaler: 12 cycles at TIME_DIV=4 gives 3
    repeat (12) @(posedge clk);
    @(negedge clk);
    csr("time_12cyc", 12'hC01, 2'b10, 32'h0, 32'd3, 1'b0);
    csr("mtvec_rst", 12'h305, 2'b10, 32'h0, 32'h0000_1000, 1'b0);

    // read-modify-write on mepc
    csr("mepc_wr", 12'h341, 2'b01, 32'h1234_5678, 32'h0, 1'b0);
    csr("mepc_set", 12'h341, 2'b10, 32'h0000_000F, 32'h1234_5678, 1'b0);
    csr("mepc_clr", 12'h341, 2'b11, 32'h0000_0078, 32'h1234_567F, 1'b0);
    csr("mepc_rd", 12'h341, 2'b10, 32'h0, 32'h1234_5607, 1'b0);
    run_step("hold", model_rd, 1'b0, 1'b0, 32'h0);

    // vectored interrupt into M
    csr("mtvec_wr", 12'h305, 2'b01, 32'h8000_0001, 32'h0000_1000, 1'b0);
    csr("mstatus_mie", 12'h300, 2'b01, 32'h0000_0008, 32'h0, 1'b0);
    trap("trap_int5", 1'b1, 5'd5, 32'h100, 32'hAB, 32'h8000_0014);
    chk("trap_int5.priv", 64'(bus.o_priv), 64'h3);
    chk("trap_int5.mstatus", 64'(bus.o_mstatus), 64'h1880);
    csr("mepc_after", 12'h341, 2'b10, 32'h0, 32'h100, 1'b0);
    csr("mcause_after", 12'h342, 2'b10, 32'h0, 32'h8000_0005, 1'b0);
    csr("mtval_after", 12'h343, 2'b10, 32'h0, 32'hAB, 1'b0);

    // drop to U via mret, delegated exception into S, sret back
    csr("medeleg_wr", 12'h302, 2'b01, 32'h100, 32'h0, 1'b0);
    csr("stvec_wr", 12'h105, 2'b01, 32'h2000, 32'h0, 1'b0);
    csr("mpp_clr", 12'h300, 2'b11, 32'h1800, 32'h1880, 1'b0);
    csr("mepc_wr2", 12'h341, 2'b01, 32'h400, 32'h100, 1'b0);
    xret("mret_to_u", 1'b1, 1'b0, 32'h400);
    chk("mret_to_u.priv", 64'(bus.o_priv), 64'h0);
    chk("mret_to_u.mstatus", 64'(bus.o_mstatus), 64'h88);
    trap("trap_deleg8", 1'b0, 5'd8, 32'h500, 32'h0, 32'h2000);
    chk("trap_deleg8.priv", 64'(bus.o_priv), 64'h1);
    chk("trap_deleg8.mstatus", 64'(bus.o_mstatus), 64'h88);
    csr("sepc_rd", 12'h141, 2'b10, 32'h0, 32'h500, 1'b0);
    csr("scause_rd", 12'h142, 2'b10, 32'h0, 32'h8, 1'b0);
    csr("sstatus_rd", 12'h100, 2'b10, 32'h0, 32'h0, 1'b0);
    csr("s_rd_mstatus", 12'h300, 2'b10, 32'h0, 32'h0, 1'b1);
    csr("s_wr_mhartid", 12'hF14, 2'b01, 32'h5, 32'h0, 1'b1);
    csr("satp_wr", 12'h180, 2'b01, 32'h8000_0001, 32'h0, 1'b0);
    chk("satp_out", 64'(bus.o_satp), 64'h8000_0001);
    xret("sret_to_u", 1'b0, 1'b0, 32'h500);
    chk("sret_to_u.priv", 64'(bus.o_priv), 64'h0);
    chk("sret_to_u.mstatus", 64'(bus.o_mstatus), 64'hA8);
    xret("u_sret_ill", 1'b0, 1'b1, 32'h0);
    xret("u_mret_ill", 1'b1, 1'b1, 32'h0);
    csr("u_time_ill", 12'hC01, 2'b10, 32'h0, 32'h0, 1'b1);
    trap("trap_exc2", 1'b0, 5'd2, 32'h700, 32'h0, 32'h8000_0000);
    chk("trap_exc2.priv", 64'(bus.o_priv), 64'h3);
    chk("trap_exc2.mstatus", 64'(bus.o_mstatus), 64'hA0);

    // machine-mode legality corners
    csr("unimpl_7c0", 12'h7C0, 2'b10, 32'h0, 32'h0, 1'b1);
    csr("m_wr_mhartid", 12'hF14, 2'b01, 32'h5, 32'h0, 1'b1);
    csr("mhartid_rd", 12'hF14, 2'b10, 32'h0, 32'h3, 1'b0);

    // trap beats mret and a CSR write in the same cycle
    bus.i_csr_addr = 12'h340; bus.i_csr_op = 2'b01; bus.i_csr_wdata = 32'hDEAD;
    bus.i_mret = 1'b1;
    trap("trap_prio", 1'b0, 5'd3, 32'h600, 32'h0, 32'h8000_0000);
    chk("trap_prio.mstatus", 64'(bus.o_mstatus), 64'h1820);
    csr("mscratch_rd", 12'h340, 2'b10, 32'h0, 32'h0, 1'b0);
    csr("mepc_prio", 12'h341, 2'b10, 32'h0, 32'h600, 1'b0);

    // sie view through mideleg
    csr("mideleg_wr", 12'h303, 2'b01, 32'h222, 32'h0, 1'b0);
    csr("mie_wr", 12'h304, 2'b01, 32'hFFF, 32'h0, 1'b0);
    csr("sie_wr0", 12'h104, 2'b01, 32'h0, 32'h222, 1'b0);
    csr("mie_rd", 12'h304, 2'b10, 32'h0, 32'hDDD, 1'b0);

    // time low-word carry into timeh
    for (k = 0; k < 8; k++) begin
      if (dut.r_presc == 2'd0) break;
      @(negedge clk);
    end
    chk("presc_sync", 64'(k < 8), 64'h1);
    force dut.r_time = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    release dut.r_time;
    repeat (3) @(posedge clk);
    @(negedge clk);
    csr("time_wrap", 12'hC01, 2'b10, 32'h0, 32'h0, 1'b0);
    csr("timeh_wrap", 12'hC81, 2'b10, 32'h0, 32'h1, 1'b0);

    // reset in the same cycle as a trap
    bus.i_trap = 1'b1; bus.i_trap_is_int = 1'b1; bus.i_trap_code = 5'd1; bus.i_trap_pc = 32'h900;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idle();
    chk("rst_trap.redirect", 64'(bus.o_redirect), 64'h0);
    chk("rst_trap.redirect_pc", 64'(bus.o_redirect_pc), 64'h0);
    chk("rst_trap.rdata", 64'(bus.o_csr_rdata), 64'h0);
    chk("rst_trap.priv", 64'(bus.o_priv), 64'h3);
    chk("rst_trap.mstatus", 64'(bus.o_mstatus), 64'h0);
    chk("rst_trap.satp", 64'(bus.o_satp), 64'h0);
    $display("step %-16s redirect=%b priv=%b", "rst_trap", bus.o_redirect, bus.o_priv);
    rst_n = 1'b1;
    csr("mtvec_rst2", 12'h305, 2'b10, 32'h0, 32'h0000_1000, 1'b0);
    csr("mepc_rst2", 12'h341, 2'b10, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
